relay_bank: RTL and testbench

//   N-channel electromechanical relay model with shared timebase, per-channel

---
 rtl/relay_bank_if.sv | 22 ++
 rtl/relay_bank.sv | 148 ++++++++++++++
 tb/tb_relay_bank.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/relay_bank_if.sv
// relay_bank_if: timebase strobe, per-channel coil/alternate-release inputs and
// the contact/motion status returned by a relay_bank instance.
interface relay_bank_if #(
  parameter int N = 4
) ();
  logic         tick;
  logic [N-1:0] e;
  logic [N-1:0] ar;
  logic [N-1:0] c;
  logic [N-1:0] moving;
  logic         settled;

  modport master (
    output tick, e, ar,
    input  c, moving, settled
  );

  modport slave (
    input  tick, e, ar,
    output c, moving, settled
  );
endinterface

// File: rtl/relay_bank.sv
// relay_bank: N independent relay channels timed by a shared tick strobe.
// Define RELAY_BOUNCE_EN to model TB ticks of make-contact bounce after pull-in.
module relay_bank #(
  parameter int N  = 4,
  parameter int T1 = 10,
  parameter int T2 = 10,
  parameter int T3 = 20,
  parameter int TB = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  relay_bank_if.slave bus
);

  localparam int MAX12  = (T1 > T2) ? T1 : T2;
  localparam int MAX123 = (MAX12 > T3) ? MAX12 : T3;
  localparam int MAXT   = (MAX123 > TB) ? MAX123 : TB;
  localparam int CW     = $clog2(MAXT + 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {OPEN, PULLING, PULLED, RELEASING} relay_state_e;

  logic [N-1:0] c_vec;
  logic [N-1:0] moving_vec;
  logic [N-1:0] bounce_busy;

  for (genvar i = 0; i < N; i++) begin : g_ch
    relay_state_e  state, state_nxt;
    logic [CW-1:0] ctr, ctr_nxt;
    logic          bounce_open;
    logic          c_ch, moving_ch;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= OPEN;
        ctr   <= '0;
      end else begin
        state <= state_nxt;
        ctr   <= ctr_nxt;
      end
    end

    // A coil change while moving returns to the prior rest state and drops any coincident tick.
    always_comb begin
      state_nxt = state;
      ctr_nxt   = ctr;
      case (state)
        OPEN: begin
          if (bus.e[i]) begin
            state_nxt = PULLING;
            ctr_nxt   = CW'(T1);
          end
        end
        PULLING: begin
          if (!bus.e[i]) begin
            state_nxt = OPEN;
            ctr_nxt   = '0;
          end else if (bus.tick && ctr != '0) begin
            if (ctr == ONE) begin
              state_nxt = PULLED;
              ctr_nxt   = '0;
            end else begin
              ctr_nxt = ctr - ONE;
            end
          end
        end
        PULLED: begin
          if (!bus.e[i]) begin
            state_nxt = RELEASING;
            ctr_nxt   = bus.ar[i] ? CW'(T3) : CW'(T2);
          end
        end
        RELEASING: begin
          if (bus.e[i]) begin
            state_nxt = PULLED;
            ctr_nxt   = '0;
          end else if (bus.tick && ctr != '0) begin
            if (ctr == ONE) begin
              state_nxt = OPEN;
              ctr_nxt   = '0;
            end else begin
              ctr_nxt = ctr - ONE;
            end
          end
        end
        default: begin
          state_nxt = OPEN;
          ctr_nxt   = '0;
        end
      endcase
    end

`ifdef RELAY_BOUNCE_EN
    logic [CW-1:0] bctr, bctr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bctr <= '0;
      end else begin
        bctr <= bctr_nxt;
      end
    end

    // Bounce runs only while resting in PULLED; odd counts hold the contact open.
    always_comb begin
      bctr_nxt = bctr;
      if (state == PULLING && state_nxt == PULLED) begin
        bctr_nxt = CW'(TB);
      end else if (state_nxt != PULLED) begin
        bctr_nxt = '0;
      end else if (bus.tick && bctr != '0) begin
        bctr_nxt = bctr - ONE;
      end
    end

    assign bounce_open    = (bctr != '0) && bctr[0];
    assign bounce_busy[i] = (bctr != '0);
`else
    assign bounce_open    = 1'b0;
    assign bounce_busy[i] = 1'b0;
`endif

    always_comb begin
      c_ch      = 1'b0;
      moving_ch = 1'b0;
      case (state)
        PULLING:   moving_ch = 1'b1;
        PULLED:    c_ch      = ~bounce_open;
        RELEASING: begin
          c_ch      = 1'b1;
          moving_ch = 1'b1;
        end
        default: begin
          c_ch      = 1'b0;
          moving_ch = 1'b0;
        end
      endcase
    end

    assign c_vec[i]      = c_ch;
    assign moving_vec[i] = moving_ch;
  end

  assign bus.c       = c_vec;
  assign bus.moving  = moving_vec;
  assign bus.settled = ~|moving_vec & ~|bounce_busy;

endmodule

// File: tb/tb_relay_bank.sv
// tb_relay_bank: directed stimulus for relay_bank with a contact-follows-coil model
// checked every cycle, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_relay_bank;

  localparam int N  = 4;
  localparam int T1 = 10;
  localparam int T2 = 10;
  localparam int T3 = 20;
  localparam int TB = 4;
`ifdef RELAY_BOUNCE_EN
  localparam int BOUNCE = TB;
`else
  localparam int BOUNCE = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  relay_bank_if #(.N(N)) bus ();

  relay_bank #(.N(N), .T1(T1), .T2(T2), .T3(T3), .TB(TB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: a contact follows its coil once the coil has disagreed with it for the
  // required number of ticks; any return to agreement cancels the pending change.
  bit m_closed [N];
  bit m_coil   [N];
  int m_count  [N];
  int m_target [N];
  int m_bounce [N];
  bit e_now;
  bit busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_closed[i] = 1'b0;
        m_coil[i]   = 1'b0;
        m_count[i]  = 0;
        m_target[i] = 0;
        m_bounce[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        e_now = bus.e[i];
        busy  = (m_coil[i] != m_closed[i]);
        if (e_now == m_closed[i]) begin
          if (m_closed[i] && !busy && bus.tick && m_bounce[i] > 0)
            m_bounce[i] = m_bounce[i] - 1;
        end else if (!busy) begin
          m_count[i]  = 0;
          m_target[i] = e_now ? T1 : (bus.ar[i] ? T3 : T2);
          m_bounce[i] = 0;
        end else if (bus.tick) begin
          m_count[i] = m_count[i] + 1;
          if (m_count[i] == m_target[i]) begin
            m_closed[i] = e_now;
            if (e_now) m_bounce[i] = BOUNCE;
          end
        end
        m_coil[i] = e_now;
      end
    end
  end

  function automatic logic [N-1:0] exp_c();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++)
      r[i] = m_closed[i] && (m_bounce[i] % 2 == 0);
    return r;
  endfunction

  function automatic logic [N-1:0] exp_moving();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++)
      r[i] = (m_coil[i] != m_closed[i]);
    return r;
  endfunction

  function automatic logic exp_settled();
    logic r;
    r = 1'b1;
    for (int i = 0; i < N; i++)
      if (m_coil[i] != m_closed[i] || m_bounce[i] != 0) r = 1'b0;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model c", 32'(bus.c), 32'(exp_c()));
      checkOutput("model moving", 32'(bus.moving), 32'(exp_moving()));
      checkOutput("model settled", 32'(bus.settled), 32'(exp_settled()));
    end
  end

  task automatic applyStimulus(input logic [N-1:0] e_val, input logic [N-1:0] ar_val, input logic tick_val);
    @(negedge clk);
    bus.e    = e_val;
    bus.ar   = ar_val;
    bus.tick = tick_val;
  endtask

  task automatic tickPeriod(input logic [N-1:0] e_val, input logic [N-1:0] ar_val);
    applyStimulus(e_val, ar_val, 1'b1);
    repeat (3) applyStimulus(e_val, ar_val, 1'b0);
  endtask

  int           on_len  [N] = '{20, 45, 90, 33};
  int           off_len [N] = '{50, 25, 80, 70};
  logic [N-1:0] ev;
  logic [N-1:0] av;

  initial begin
    bus.e    = '0;
    bus.ar   = '0;
    bus.tick = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and asynchronous reset during pull-in
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("reset c", 32'(bus.c), 32'h0);
    checkOutput("reset moving", 32'(bus.moving), 32'h0);
    checkOutput("reset settled", 32'(bus.settled), 32'h1);
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    repeat (3) tickPeriod(4'b0001, 4'b0000);
    checkOutput("pulling moving", 32'(bus.moving), 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset c", 32'(bus.c), 32'h0);
    checkOutput("async reset moving", 32'(bus.moving), 32'h0);
    checkOutput("async reset settled", 32'(bus.settled), 32'h1);
    bus.e = '0;
    #1 rst_n = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 1'b0);

    // Make and break on channel 0
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    repeat (9) tickPeriod(4'b0001, 4'b0000);
    checkOutput("make tick9 c", 32'(bus.c), 32'h0);
    checkOutput("make tick9 moving", 32'(bus.moving), 32'h1);
    tickPeriod(4'b0001, 4'b0000);
    checkOutput("make tick10 c", 32'(bus.c), 32'h1);
    checkOutput("make tick10 moving", 32'(bus.moving), 32'h0);
    checkOutput("make tick10 settled", 32'(bus.settled), 32'(BOUNCE == 0));
`ifdef RELAY_BOUNCE_EN
    for (int k = 0; k < 4; k++) begin
      tickPeriod(4'b0001, 4'b0000);
      checkOutput("bounce c", 32'(bus.c), 32'(k % 2));
      checkOutput("bounce settled", 32'(bus.settled), 32'(k == 3));
    end
`endif
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    repeat (9) tickPeriod(4'b0000, 4'b0000);
    checkOutput("break tick9 c", 32'(bus.c), 32'h1);
    checkOutput("break tick9 moving", 32'(bus.moving), 32'h1);
    tickPeriod(4'b0000, 4'b0000);
    checkOutput("break tick10 c", 32'(bus.c), 32'h0);
    checkOutput("break tick10 settled", 32'(bus.settled), 32'h1);

    // Alternate release on channel 1, ar toggled while releasing
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    repeat (10) tickPeriod(4'b0010, 4'b0000);
    checkOutput("alt make c", 32'(bus.c), 32'h2);
    applyStimulus(4'b0000, 4'b0010, 1'b0);
    for (int k = 0; k < 19; k++)
      tickPeriod(4'b0000, (k % 2 == 1) ? 4'b0010 : 4'b0000);
    checkOutput("alt tick19 c", 32'(bus.c), 32'h2);
    tickPeriod(4'b0000, 4'b0000);
    checkOutput("alt tick20 c", 32'(bus.c), 32'h0);

    // Abort during pull-in, then re-pull during release on channel 2
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    repeat (5) tickPeriod(4'b0100, 4'b0000);
    checkOutput("abort pre moving", 32'(bus.moving), 32'h4);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("abort c", 32'(bus.c), 32'h0);
    checkOutput("abort moving", 32'(bus.moving), 32'h0);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    repeat (10) tickPeriod(4'b0100, 4'b0000);
    checkOutput("repull make c", 32'(bus.c), 32'h4);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    repeat (7) tickPeriod(4'b0000, 4'b0000);
    checkOutput("repull releasing moving", 32'(bus.moving), 32'h4);
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    checkOutput("repull c", 32'(bus.c), 32'h4);
    checkOutput("repull moving", 32'(bus.moving), 32'h0);
    repeat (12) tickPeriod(4'b0100, 4'b0000);
    checkOutput("repull held c", 32'(bus.c), 32'h4);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    repeat (10) tickPeriod(4'b0000, 4'b0000);
    checkOutput("repull break c", 32'(bus.c), 32'h0);

`ifdef RELAY_BOUNCE_EN
    // Coil drop in the middle of bounce
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    repeat (10) tickPeriod(4'b0001, 4'b0000);
    tickPeriod(4'b0001, 4'b0000);
    checkOutput("midbounce low c", 32'(bus.c), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("midbounce drop c", 32'(bus.c), 32'h1);
    checkOutput("midbounce drop moving", 32'(bus.moving), 32'h1);
    repeat (10) tickPeriod(4'b0000, 4'b0000);
`endif

    // All channels with staggered coils; ticks every third clock
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        ev[i] = ((cyc + 7 * i) % (on_len[i] + off_len[i])) < on_len[i];
        av[i] = ((cyc / 8) % 2) != (i % 2);
      end
      applyStimulus(ev, av, (cyc % 3) == 0);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    repeat (25) tickPeriod(4'b0000, 4'b0000);
    checkOutput("idle c", 32'(bus.c), 32'h0);
    checkOutput("idle settled", 32'(bus.settled), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
